vga_fb_scanout: RTL

//  Downstream stage of the VGA timing generator. Consumes hs/vs/de and the active_x/active_y

---
 rtl/vga_fb_scanout.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: framebuffer scan-out stage behind the VGA timing generator.
// Maps screen coordinates to RGB332 framebuffer words with 2^SCALE_SHIFT pixel
// replication, expands the fetched pixels to RGB888, and delays hs/vs/de to
// match. Two display buffers are supported; the swap happens only at vsync start.
module vga_fb_scanout #(
  parameter int                SCALE_SHIFT = 2,
  parameter int                FB_W_LOG2   = 8,
  parameter int                FB_H        = 192,
  parameter int                ADDR_W      = 16,
  parameter int                RAM_LAT     = 1,
  parameter logic [ADDR_W-1:0] FB0_BASE    = '0,
  parameter logic [ADDR_W-1:0] FB1_BASE    = '0,
  parameter logic              VS_POL      = 1'b0,
  parameter logic [23:0]       BORDER_RGB  = 24'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              de_in,
  input  logic [11:0]       x_in,
  input  logic [11:0]       y_in,
  input  logic              buf_sel_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_data,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [7:0]        rgb_r,
  output logic [7:0]        rgb_g,
  output logic [7:0]        rgb_b,
  output logic              buf_sel_cur,
  output logic [15:0]       frame_cnt
);

  // Sideband that travels alongside the RAM fetch.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic in_fb;
  } side_t;

  logic [11:0]       fx;
  logic [11:0]       fy;
  logic              in_fb;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] lin_addr;
  logic              vs_prev;
  logic              vs_start;
  side_t             s1;
  side_t             dly [RAM_LAT];
  side_t             last;
  logic [2:0]        r3;
  logic [2:0]        g3;
  logic [1:0]        b2;

  // Scale screen coordinates down to framebuffer coordinates and form the linear address.
  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    fx       = x_in >> SCALE_SHIFT;
    fy       = y_in >> SCALE_SHIFT;
    in_fb    = de_in && (32'(fx) < (32'd1 << FB_W_LOG2)) && (32'(fy) < 32'(FB_H));
    base     = buf_sel_cur ? FB1_BASE : FB0_BASE;
    lin_addr = ADDR_W'((32'(fy) << FB_W_LOG2) | 32'(fx[FB_W_LOG2-1:0]));
  end

  // Vsync start is the transition of vs_in into its active level.
  assign vs_start = (vs_in == VS_POL) && (vs_prev != VS_POL);

  // Address stage: issue the read and capture sideband; address holds outside the buffer.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr <= '0;
      ram_rd   <= 1'b0;
      s1       <= '0;
    end else begin
      ram_rd <= in_fb;
      s1     <= '{hs: hs_in, vs: vs_in, de: de_in, in_fb: in_fb};
      if (in_fb) ram_addr <= base + lin_addr;
    end
  end

  // Sideband delay line matching the RAM read latency.
  // NOTE: this is a handful of flops, not a memory, so resetting every entry is cheap and keeps outputs clean after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAM_LAT; i++) dly[i] <= '0;
    end else begin
      dly[0] <= s1;
      for (int i = 1; i < RAM_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign last         = dly[RAM_LAT-1];
  assign {r3, g3, b2} = ram_data;

  // Output stage: RGB332 to RGB888 by bit replication, border colour, or black when blanked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs    <= 1'b0;
      vs    <= 1'b0;
      de    <= 1'b0;
      rgb_r <= '0;
      rgb_g <= '0;
      rgb_b <= '0;
    end else begin
      hs <= last.hs;
      vs <= last.vs;
      de <= last.de;
      if (!last.de) begin
        {rgb_r, rgb_g, rgb_b} <= '0;
      end else if (!last.in_fb) begin
        {rgb_r, rgb_g, rgb_b} <= BORDER_RGB;
      end else begin
        rgb_r <= {r3, r3, r3[2:1]};
        rgb_g <= {g3, g3, g3[2:1]};
        rgb_b <= {4{b2}};
      end
    end
  end

  // Frame bookkeeping: latch the requested buffer and count frames at vsync start only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev     <= VS_POL;
      buf_sel_cur <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      vs_prev <= vs_in;
      if (vs_start) begin
        buf_sel_cur <= buf_sel_req;
        frame_cnt   <= frame_cnt + 16'd1;
      end
    end
  end

endmodule
